// File: rtl/pll_reset_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_reset_pkg
// Shared types and helpers for the PLL reset sequencer.
//   state_t   : sequencer states
//   max2      : larger of two ints (for sizing the shared counter)
//   cnt_width : bits needed to count 0..max_cycles-1 (at least 1)
//   sat_inc   : 8-bit increment that holds at 255
// ---------------------------------------------------------------------------
package pll_reset_pkg;

    typedef enum logic [2:0] {
        S_PLLRST,
        S_WAITLOCK,
        S_STABLE,
        S_RUN,
        S_LOST
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int cnt_width(input int max_cycles);
        return (max_cycles < 2) ? 1 : $clog2(max_cycles);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pll_reset_seq_if.sv
// ---------------------------------------------------------------------------
// pll_reset_seq_if
// Groups the PLL-facing and core-facing signals of the reset sequencer.
//   locked        : PLL lock, asynchronous to the board clock
//   key_n         : user reset key, active-low, bouncing
//   pll_rst       : PLL reset, active-high
//   core_rst_n    : core reset, active-low
//   loss_count    : saturating lock-loss event count
//   timeout_count : saturating lock-timeout event count
// Modports: master = board/environment side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface pll_reset_seq_if;

    logic       locked;
    logic       key_n;
    logic       pll_rst;
    logic       core_rst_n;
    logic [7:0] loss_count;
    logic [7:0] timeout_count;

    modport master (
        output locked, key_n,
        input  pll_rst, core_rst_n, loss_count, timeout_count
    );

    modport slave (
        input  locked, key_n,
        output pll_rst, core_rst_n, loss_count, timeout_count
    );

endinterface

// File: rtl/pll_reset_seq_sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
// Plain flop-chain synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, loads RST_VAL into every stage
//   i_d   : asynchronous input
//   o_q   : synchronized output (STAGES cycles of latency)
// ---------------------------------------------------------------------------
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // NOTE: flops take non-blocking assignments so every stage samples the
    // value its neighbour held before the edge, giving a true shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {STAGES{RST_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// ---------------------------------------------------------------------------
// pll_reset_seq
// Reset sequencer between the board reset and a PLL. Pulses the PLL reset,
// waits for lock, requires lock to be stable before releasing the core reset,
// rides out short lock glitches, re-resets the PLL on long loss or timeout,
// and turns a debounced user key press into a core-only reset.
//   clock   : raw board clock, never a PLL output
//   reset_n : asynchronous active-low reset; its release must be
//             synchronous to clock
//   bus     : pll_reset_seq_if.slave (locked, key_n in; pll_rst,
//             core_rst_n, loss_count, timeout_count out)
// pll_rst and core_rst_n are both registered decodes of the next state, so
// core_rst_n can never be high while pll_rst is high.
// ---------------------------------------------------------------------------
module pll_reset_seq
    import pll_reset_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 32,
    parameter int LOCK_TIMEOUT   = 500000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int LOSS_GRACE     = 64,
    parameter int DEBOUNCE       = 65536
) (
    input  logic           clock,
    input  logic           reset_n,
    pll_reset_seq_if.slave bus
);

    localparam int MAX_CYC = max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                  max2(STABLE_CYCLES, LOSS_GRACE));
    localparam int CW      = cnt_width(MAX_CYC);
    localparam int DW      = cnt_width(DEBOUNCE);

    localparam logic [CW-1:0] PLL_LAST     = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GRACE_LAST   = CW'(LOSS_GRACE - 1);
    localparam logic [DW-1:0] DB_LAST      = DW'(DEBOUNCE - 1);

    logic w_locked_s;
    logic w_key_s;

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_locked (
        .clk   (clock),
        .rst_n (reset_n),
        .i_d   (bus.locked),
        .o_q   (w_locked_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_key (
        .clk   (clock),
        .rst_n (reset_n),
        .i_d   (bus.key_n),
        .o_q   (w_key_s)
    );

    // Key debounce: while armed, count consecutive low cycles; a full run
    // fires one event and disarms. While disarmed, count consecutive high
    // cycles; a full run re-arms. Any break in the run restarts the count.
    logic          r_db_armed;
    logic [DW-1:0] r_db_cnt;
    logic          w_db_hit;
    logic          w_key_event;

    assign w_db_hit    = (r_db_cnt == DB_LAST);
    assign w_key_event = r_db_armed & ~w_key_s & w_db_hit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_db_armed <= 1'b1;
            r_db_cnt   <= '0;
        end else if (r_db_armed != w_key_s) begin
            if (w_db_hit) begin
                r_db_armed <= ~r_db_armed;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    // Sequencer
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_loss_inc;
    logic          w_timeout_inc;
    logic          r_pll_rst;
    logic          r_core_rst_n;
    logic [7:0]    r_loss_count;
    logic [7:0]    r_timeout_count;

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + 1'b1;
        w_loss_inc    = 1'b0;
        w_timeout_inc = 1'b0;
        unique case (r_state)
            S_PLLRST: begin
                if (r_cnt == PLL_LAST) begin
                    w_state_nxt = S_WAITLOCK;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAITLOCK: begin
                if (w_locked_s) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_nxt   = S_PLLRST;
                    w_cnt_nxt     = '0;
                    w_timeout_inc = 1'b1;
                end
            end
            S_STABLE: begin
                // A dropout before release is just "not locked yet", not a loss.
                if (!w_locked_s) begin
                    w_state_nxt = S_WAITLOCK;
                    w_cnt_nxt   = '0;
                end else if (w_key_event) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                w_cnt_nxt = '0;
                // Lock loss takes priority over a simultaneous key event.
                if (!w_locked_s) begin
                    w_state_nxt = S_LOST;
                    w_loss_inc  = 1'b1;
                end else if (w_key_event) begin
                    w_state_nxt = S_STABLE;
                end
            end
            S_LOST: begin
                if (w_locked_s) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == GRACE_LAST) begin
                    w_state_nxt = S_PLLRST;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_PLLRST;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_PLLRST;
            r_cnt           <= '0;
            r_pll_rst       <= 1'b1;
            r_core_rst_n    <= 1'b0;
            r_loss_count    <= '0;
            r_timeout_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pll_rst    <= (w_state_nxt == S_PLLRST);
            r_core_rst_n <= (w_state_nxt == S_RUN);
            if (w_loss_inc) begin
                r_loss_count <= sat_inc(r_loss_count);
            end
            if (w_timeout_inc) begin
                r_timeout_count <= sat_inc(r_timeout_count);
            end
        end
    end

    assign bus.pll_rst       = r_pll_rst;
    assign bus.core_rst_n    = r_core_rst_n;
    assign bus.loss_count    = r_loss_count;
    assign bus.timeout_count = r_timeout_count;

endmodule

// File: tb/tb_pll_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_seq
// Directed bench for pll_reset_seq with small timing parameters:
// SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8,
// LOSS_GRACE=5, DEBOUNCE=3. Inputs change 1 ns after a rising edge and
// outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_pll_reset_seq;

    logic clock;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    pll_reset_seq_if bus();

    pll_reset_seq #(
        .SYNC_STAGES    (2),
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (8),
        .LOSS_GRACE     (5),
        .DEBOUNCE       (3)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       locked;
        logic       key_n;
        int         cycles;
        logic       exp_pll;
        logic       exp_core;
        logic [7:0] exp_loss;
        logic [7:0] exp_to;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Leaves the bench 1 ns after an edge with reset just released;
    // the next rising edge is edge 1.
    task automatic do_reset();
        reset_n    = 1'b0;
        bus.locked = 1'b0;
        bus.key_n  = 1'b1;
        tick(3);
        reset_n = 1'b1;
    endtask

    task automatic wait_core(input logic val, input int limit, input string name);
        int n = 0;
        while (bus.core_rst_n !== val && n < limit) begin
            tick(1);
            n++;
        end
        check(name, 32'(bus.core_rst_n), 32'(val));
    endtask

    // Reset, lock, and return on the edge where core_rst_n has just risen.
    task automatic bring_up();
        do_reset();
        tick(6);
        bus.locked = 1'b1;
        wait_core(1'b1, 40, "bring_up");
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic exp_core;
        logic exp_pll;
        logic seen;
        int   hi_cnt;

        // -------- power-up lock: table-driven, edge numbers after release
        //                    lk    key   n  pll   core  loss  to
        vecs[0] = '{1'b0, 1'b1, 1, 1'b1, 1'b0, 8'd0, 8'd0}; // edge 1
        vecs[1] = '{1'b0, 1'b1, 2, 1'b1, 1'b0, 8'd0, 8'd0}; // edge 3
        vecs[2] = '{1'b0, 1'b1, 1, 1'b0, 1'b0, 8'd0, 8'd0}; // edge 4: pulse ends
        vecs[3] = '{1'b0, 1'b1, 6, 1'b0, 1'b0, 8'd0, 8'd0}; // edge 10
        vecs[4] = '{1'b1, 1'b1, 10, 1'b0, 1'b0, 8'd0, 8'd0}; // edge 20: still held
        vecs[5] = '{1'b1, 1'b1, 1, 1'b0, 1'b1, 8'd0, 8'd0}; // edge 21: release
        vecs[6] = '{1'b1, 1'b1, 5, 1'b0, 1'b1, 8'd0, 8'd0}; // edge 26

        reset_n    = 1'b0;
        bus.locked = 1'b0;
        bus.key_n  = 1'b1;
        tick(3);
        check("rst_pll", 32'(bus.pll_rst), 32'd1);
        check("rst_core", 32'(bus.core_rst_n), 32'd0);
        check("rst_loss", 32'(bus.loss_count), 32'd0);
        check("rst_to", 32'(bus.timeout_count), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            bus.locked = vecs[i].locked;
            bus.key_n  = vecs[i].key_n;
            tick(vecs[i].cycles);
            check($sformatf("pu%0d_pll", i), 32'(bus.pll_rst), 32'(vecs[i].exp_pll));
            check($sformatf("pu%0d_core", i), 32'(bus.core_rst_n), 32'(vecs[i].exp_core));
            check($sformatf("pu%0d_loss", i), 32'(bus.loss_count), 32'(vecs[i].exp_loss));
            check($sformatf("pu%0d_to", i), 32'(bus.timeout_count), 32'(vecs[i].exp_to));
        end

        // -------- no lock: 4-cycle pulse every 24 cycles
        do_reset();
        seen = 1'b0;
        for (int k = 1; k <= 73; k++) begin
            tick(1);
            exp_pll = ((k % 24) < 4);
            check($sformatf("nolock_pll_e%0d", k), 32'(bus.pll_rst), 32'(exp_pll));
            check($sformatf("nolock_to_e%0d", k), 32'(bus.timeout_count), 32'(k / 24));
            if (bus.core_rst_n !== 1'b0) seen = 1'b1;
        end
        check("nolock_core_held", 32'(seen), 32'd0);

        // -------- glitch recovery: locked low for 3 cycles
        bring_up();
        bus.locked = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            if (k == 3) bus.locked = 1'b1;
            exp_core = (k <= 2) || (k >= 14);
            check($sformatf("glitch_core_e%0d", k), 32'(bus.core_rst_n), 32'(exp_core));
            if (bus.pll_rst !== 1'b0) seen = 1'b1;
        end
        check("glitch_no_pll", 32'(seen), 32'd0);
        check("glitch_loss", 32'(bus.loss_count), 32'd1);

        // -------- long loss: locked low for 20 cycles
        bring_up();
        bus.locked = 1'b0;
        hi_cnt = 0;
        for (int k = 1; k <= 32; k++) begin
            tick(1);
            if (k == 20) bus.locked = 1'b1;
            exp_pll  = (k >= 8) && (k <= 11);
            exp_core = (k <= 2) || (k >= 31);
            check($sformatf("long_pll_e%0d", k), 32'(bus.pll_rst), 32'(exp_pll));
            check($sformatf("long_core_e%0d", k), 32'(bus.core_rst_n), 32'(exp_core));
            if (bus.pll_rst === 1'b1) hi_cnt++;
        end
        check("long_pll_width", 32'(hi_cnt), 32'd4);
        check("long_loss", 32'(bus.loss_count), 32'd1);
        check("long_to", 32'(bus.timeout_count), 32'd0);

        // -------- key press: bounces, a 10-cycle hold, then a second press
        bring_up();
        seen = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus.key_n = 1'b0;
            tick(1);
            bus.key_n = 1'b1;
            tick(3);
            if (bus.core_rst_n !== 1'b1) seen = 1'b1;
        end
        check("key_bounce_ignored", 32'(seen), 32'd0);
        bus.key_n = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            tick(1);
            if (k == 10) bus.key_n = 1'b1;
            if (k == 20) bus.key_n = 1'b0;
            exp_core = (k <= 4) || ((k >= 13) && (k <= 24));
            check($sformatf("key_core_e%0d", k), 32'(bus.core_rst_n), 32'(exp_core));
            if (bus.pll_rst !== 1'b0) seen = 1'b1;
        end
        check("key_no_pll", 32'(seen), 32'd0);
        check("key_loss", 32'(bus.loss_count), 32'd0);
        bus.key_n = 1'b1;

        // -------- reset_n asserted mid-operation
        do_reset();
        tick(6);
        bus.locked = 1'b1;
        tick(6);
        check("mid_stable_pll", 32'(bus.pll_rst), 32'd0);
        check("mid_stable_core", 32'(bus.core_rst_n), 32'd0);
        reset_n = 1'b0;
        #1;
        check("mid_stable_rst_pll", 32'(bus.pll_rst), 32'd1);
        check("mid_stable_rst_core", 32'(bus.core_rst_n), 32'd0);

        bring_up();
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_run_rst_core", 32'(bus.core_rst_n), 32'd0);
        check("mid_run_rst_pll", 32'(bus.pll_rst), 32'd1);

        // -------- 300 loss events saturate loss_count at 255
        bring_up();
        for (int i = 0; i < 300; i++) begin
            bus.locked = 1'b0;
            tick(2);
            bus.locked = 1'b1;
            wait_core(1'b0, 10, "sat_fall");
            wait_core(1'b1, 20, "sat_rise");
            if (i == 0 || i == 253 || i == 254 || i == 255 || i == 299) begin
                check($sformatf("sat_loss_after_%0d", i + 1), 32'(bus.loss_count),
                      32'((i + 1 > 255) ? 255 : i + 1));
            end
        end
        check("sat_to", 32'(bus.timeout_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
